rect_to_polar: RTL and testbench

Iterative CORDIC vectoring engine that converts a signed rectangular coordinate pair (x, y) into magnitude and angle. It is the inverse of the single-constant-rotation block, which produces X/Y from a radius and an angle. It sits downstream of any stage producing Cartesian samples and hands polar results back to the rotation datapath. One conversion runs at a time under a start/done handshake; the block resolves one micro-rotation per clock.

---
 rtl/rect_to_polar.sv | 192 +++++++++++++++++++
 tb/tb_rect_to_polar.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_to_polar.sv
// rect_to_polar: iterative CORDIC vectoring engine. Converts a signed Q5.8
// (x, y) pair into a gain-compensated magnitude and a binary angle
// (value * pi / 8192 rad), resolving one micro-rotation per clock under a
// start/done handshake.
module rect_to_polar #(
  parameter int unsigned ITER = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [13:0] x_in,
  input  logic signed [13:0] y_in,
  output logic               busy,
  output logic               done,
  output logic        [13:0] r_out,
  output logic signed [13:0] theta_out,
  output logic               zero
);

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StComp
  } state_e;

  state_e state_q, state_d;

  // 17-bit working vector leaves headroom for the ~1.65 CORDIC gain at
  // full-scale diagonal inputs after the quadrant pre-rotation.
  logic signed [16:0] x_q, x_d;
  logic signed [16:0] y_q, y_d;
  logic signed [13:0] z_q, z_d;
  logic        [3:0]  i_q, i_d;
  logic               zero_flag_q, zero_flag_d;

  logic               done_q, done_d;
  logic        [13:0] r_q, r_d;
  logic signed [13:0] theta_q, theta_d;
  logic               zero_q, zero_d;

  logic signed [16:0] x_ext, y_ext;
  logic signed [16:0] x_sh, y_sh;
  logic signed [16:0] r_full;

  // Arctangent of 2^-i in binary-angle units (8192 = pi).
  function automatic logic signed [13:0] atan_lut(input logic [3:0] idx);
    logic signed [13:0] val;
    case (idx)
      4'd0:    val = 14'sd2048;
      4'd1:    val = 14'sd1209;
      4'd2:    val = 14'sd639;
      4'd3:    val = 14'sd324;
      4'd4:    val = 14'sd163;
      4'd5:    val = 14'sd81;
      4'd6:    val = 14'sd41;
      4'd7:    val = 14'sd20;
      4'd8:    val = 14'sd10;
      4'd9:    val = 14'sd5;
      4'd10:   val = 14'sd3;
      4'd11:   val = 14'sd1;
      default: val = 14'sd0;
    endcase
    return val;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one cycle in COMP after the last micro-rotation.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StIter;
      StIter:  if (i_q == 4'(ITER - 1)) state_d = StComp;
      StComp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: capture/pre-rotate, micro-rotate, compensate.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    i_d         = i_q;
    zero_flag_d = zero_flag_q;
    done_d      = 1'b0;
    r_d         = r_q;
    theta_d     = theta_q;
    zero_d      = zero_q;
    x_ext       = {{3{x_in[13]}}, x_in};
    y_ext       = {{3{y_in[13]}}, y_in};
    x_sh        = x_q >>> i_q;
    y_sh        = y_q >>> i_q;
    // 1/2 + 1/8 - 1/64 - 1/512 ~= 0.60742, close to 1/K for 8..12 steps.
    r_full      = (x_q >>> 1) + (x_q >>> 3) - (x_q >>> 6) - (x_q >>> 9);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          zero_flag_d = (x_in == '0) && (y_in == '0);
          i_d         = '0;
          // Rotate left-half-plane vectors by +/-90 deg so CORDIC converges.
          if (!x_ext[16]) begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = '0;
          end else if (!y_ext[16]) begin
            x_d = y_ext;
            y_d = -x_ext;
            z_d = 14'sd4096;
          end else begin
            x_d = -y_ext;
            y_d = x_ext;
            z_d = -14'sd4096;
          end
        end
      end
      StIter: begin
        if (!y_q[16]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_lut(i_q);
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_lut(i_q);
        end
        i_d = i_q + 4'd1;
      end
      StComp: begin
        done_d = 1'b1;
        zero_d = zero_flag_q;
        if (zero_flag_q) begin
          r_d     = '0;
          theta_d = '0;
        end else begin
          theta_d = z_q;
          if (r_full < 17'sd0) begin
            r_d = '0;
          end else if (r_full > 17'sd16383) begin
            r_d = 14'd16383;
          end else begin
            r_d = r_full[13:0];
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      i_q         <= '0;
      zero_flag_q <= 1'b0;
      done_q      <= 1'b0;
      r_q         <= '0;
      theta_q     <= '0;
      zero_q      <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      i_q         <= i_d;
      zero_flag_q <= zero_flag_d;
      done_q      <= done_d;
      r_q         <= r_d;
      theta_q     <= theta_d;
      zero_q      <= zero_d;
    end
  end

  // Output decode; busy is low in the done cycle because COMP returns to IDLE.
  always_comb begin
    busy      = (state_q != StIdle);
    done      = done_q;
    r_out     = r_q;
    theta_out = theta_q;
    zero      = zero_q;
  end

endmodule

// File: tb/tb_rect_to_polar.sv
// tb_rect_to_polar: directed accuracy checks against ideal polar math, plus
// randomized conversions checked bit-exactly against a loop-level model of
// the vectoring algorithm.
module tb_rect_to_polar;

  localparam int ITER   = 12;
  localparam int LAT    = ITER + 1;  // start edge to done edge
  localparam int PERIOD = ITER + 2;  // start edges when start is held high

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic signed [13:0] x_in = '0;
  logic signed [13:0] y_in = '0;
  logic               busy;
  logic               done;
  logic        [13:0] r_out;
  logic signed [13:0] theta_out;
  logic               zero;

  int total = 0;
  int bad   = 0;

  rect_to_polar #(.ITER(ITER)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .r_out     (r_out),
    .theta_out (theta_out),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Angle difference folded onto the 14-bit circle.
  function automatic int adiff(input int a, input int b);
    int d;
    d = (a - b) & 16383;
    return (d >= 8192) ? d - 16384 : d;
  endfunction

  // Algorithm-level reference: quadrant fold, ITER shift-add rotations,
  // constant gain compensation, saturation, 14-bit angle wrap.
  function automatic void model(input int xi, input int yi,
                                output int r, output int th, output bit zf);
    int tbl [12] = '{2048, 1209, 639, 324, 163, 81, 41, 20, 10, 5, 3, 1};
    int x, y, z, t, xs, ys;
    x = xi; y = yi; z = 0;
    if (xi < 0) begin
      if (yi >= 0) begin x = yi;  y = -xi; z = 4096;  end
      else         begin x = -yi; y = xi;  z = -4096; end
    end
    for (int i = 0; i < ITER; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (y >= 0) begin x = x + ys; y = y - xs; z = z + tbl[i]; end
      else        begin x = x - ys; y = y + xs; z = z - tbl[i]; end
    end
    r = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9);
    if (r < 0) r = 0;
    if (r > 16383) r = 16383;
    t  = z & 16383;
    th = (t >= 8192) ? t - 16384 : t;
    zf = (xi == 0) && (yi == 0);
    if (zf) begin r = 0; th = 0; end
  endfunction

  // One conversion; lat is the number of edges from start to done (0 = timeout).
  task automatic run_one(input int xi, input int yi, output int lat);
    @(negedge clk);
    start = 1'b1;
    x_in  = 14'(xi);
    y_in  = 14'(yi);
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
    total++; if (r_out !== 14'd0) begin bad++; $display("FAIL rst_r got=%0d want=0", r_out); end
    total++; if (theta_out !== 14'sd0) begin
      bad++; $display("FAIL rst_theta got=%0d want=0", theta_out);
    end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL rst_zero got=%b want=0", zero); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_idle got=%b want=0", busy); end
  endtask

  task automatic test_axis();
    int lat, rm, tm;
    bit zm;
    run_one(1920, 0, lat);
    total++; if (lat != LAT) begin bad++; $display("FAIL axis_lat got=%0d want=%0d", lat, LAT); end
    total++; if (iabs(int'(r_out) - 1920) > 3) begin
      bad++; $display("FAIL axis_r got=%0d want=1920+/-3", r_out);
    end
    total++; if (iabs(adiff(int'(theta_out), 0)) > 2) begin
      bad++; $display("FAIL axis_theta got=%0d want=0+/-2", theta_out);
    end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL axis_zero got=%b want=0", zero); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL axis_busy got=%b want=0", busy); end
    model(1920, 0, rm, tm, zm);
    repeat (3) @(posedge clk);
    #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL axis_pulse got=%b want=0", done); end
    total++; if (r_out !== 14'(rm)) begin
      bad++; $display("FAIL axis_hold_r got=%0d want=%0d", r_out, rm);
    end
  endtask

  task automatic test_quadrants();
    int qx [5] = '{0, -1920, 0, 1000, -8192};
    int qy [5] = '{1920, 0, -1920, 1000, -8192};
    int qr [5] = '{1920, 1920, 1920, 1414, 11585};
    int qt [5] = '{4096, -8192, -4096, 2048, -6144};
    int lat;
    for (int k = 0; k < 5; k++) begin
      run_one(qx[k], qy[k], lat);
      total++; if (lat != LAT) begin
        bad++; $display("FAIL quad_lat[%0d] got=%0d want=%0d", k, lat, LAT);
      end
      total++; if (iabs(int'(r_out) - qr[k]) > 3) begin
        bad++; $display("FAIL quad_r[%0d] got=%0d want=%0d+/-3", k, r_out, qr[k]);
      end
      total++; if (iabs(adiff(int'(theta_out), qt[k])) > 2) begin
        bad++; $display("FAIL quad_theta[%0d] got=%0d want=%0d+/-2", k, theta_out, qt[k]);
      end
    end
  endtask

  task automatic test_zero();
    int lat;
    run_one(0, 0, lat);
    total++; if (lat != LAT) begin bad++; $display("FAIL zero_lat got=%0d want=%0d", lat, LAT); end
    total++; if (r_out !== 14'd0) begin bad++; $display("FAIL zero_r got=%0d want=0", r_out); end
    total++; if (theta_out !== 14'sd0) begin
      bad++; $display("FAIL zero_theta got=%0d want=0", theta_out);
    end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL zero_flag got=%b want=1", zero); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL zero_hold got=%b want=1", zero); end
    run_one(1920, 0, lat);
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL zero_clear got=%b want=0", zero); end
  endtask

  task automatic test_random();
    int xi, yi, lat, rm, tm;
    bit zm;
    for (int k = 0; k < 30; k++) begin
      xi = int'($urandom_range(0, 16383)) - 8192;
      yi = int'($urandom_range(0, 16383)) - 8192;
      model(xi, yi, rm, tm, zm);
      run_one(xi, yi, lat);
      total++; if (lat != LAT) begin
        bad++; $display("FAIL rnd_lat (%0d,%0d) got=%0d want=%0d", xi, yi, lat, LAT);
      end
      total++; if (r_out !== 14'(rm) || theta_out !== 14'(tm) || zero !== zm) begin
        bad++;
        $display("FAIL rnd_result (%0d,%0d) got r=%0d th=%0d z=%b want r=%0d th=%0d z=%b",
                 xi, yi, r_out, theta_out, zero, rm, tm, zm);
      end
    end
  endtask

  // Start held high with fresh inputs every cycle; accepted starts are
  // PERIOD edges apart (LAT edges of work, then start sampled after done).
  task automatic test_back_to_back();
    int bx[$], by[$];
    int xi, yi, idx, rm, tm;
    bit zm, exp_done;
    for (int k = 0; k < 4 * PERIOD + LAT + 1; k++) begin
      @(negedge clk);
      if (k == PERIOD) begin
        xi = 0; yi = 0;
      end else begin
        xi = int'($urandom_range(0, 16383)) - 8192;
        yi = int'($urandom_range(0, 16383)) - 8192;
      end
      start = 1'b1;
      x_in  = 14'(xi);
      y_in  = 14'(yi);
      bx.push_back(xi);
      by.push_back(yi);
      @(posedge clk);
      #1;
      exp_done = (k >= LAT) && (((k - LAT) % PERIOD) == 0);
      total++; if (done !== exp_done) begin
        bad++; $display("FAIL b2b_done edge=%0d got=%b want=%b", k, done, exp_done);
      end
      total++; if (busy !== !exp_done) begin
        bad++; $display("FAIL b2b_busy edge=%0d got=%b want=%b", k, busy, !exp_done);
      end
      if (exp_done) begin
        idx = k - LAT;
        model(bx[idx], by[idx], rm, tm, zm);
        total++; if (r_out !== 14'(rm) || theta_out !== 14'(tm) || zero !== zm) begin
          bad++;
          $display("FAIL b2b_result edge=%0d got r=%0d th=%0d z=%b want r=%0d th=%0d z=%b",
                   k, r_out, theta_out, zero, rm, tm, zm);
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 40 && busy !== 1'b0; n++) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", busy); end
  endtask

  task automatic test_reset_abort();
    int lat, rm, tm, pulses;
    bit zm;
    run_one(1920, 0, lat);
    total++; if (r_out === 14'd0) begin
      bad++; $display("FAIL abort_pre_r got=%0d want=nonzero", r_out);
    end
    @(negedge clk);
    start = 1'b1;
    x_in  = 14'sd1000;
    y_in  = -14'sd500;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done); end
    total++; if (r_out !== 14'd0) begin bad++; $display("FAIL abort_r got=%0d want=0", r_out); end
    total++; if (theta_out !== 14'sd0) begin
      bad++; $display("FAIL abort_theta got=%0d want=0", theta_out);
    end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL abort_zero got=%b want=0", zero); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) pulses++;
    end
    total++; if (pulses != 0) begin
      bad++; $display("FAIL abort_no_done got=%0d want=0", pulses);
    end
    model(-1000, 1500, rm, tm, zm);
    run_one(-1000, 1500, lat);
    total++; if (lat != LAT) begin bad++; $display("FAIL abort_lat got=%0d want=%0d", lat, LAT); end
    total++; if (r_out !== 14'(rm) || theta_out !== 14'(tm) || zero !== zm) begin
      bad++;
      $display("FAIL abort_result got r=%0d th=%0d z=%b want r=%0d th=%0d z=%b",
               r_out, theta_out, zero, rm, tm, zm);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_axis();
    test_quadrants();
    test_zero();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
